vrased_reset_seq: RTL and testbench
===================================

VRASED_RESET_SEQ -- requirements
Module: vrased_reset_seq

Interface
REQ-001 The block SHALL have parameter RESET_HANDLER, default 16'h0000, giving the PC value that marks re-entry to the reset vector.
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 8, giving the reset pulse length in cycles; the legal range is 1..255.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: synchronous active-low block reset.
REQ-005 The block SHALL have port pc, input, 16 bits: the CPU program counter.
REQ-006 The block SHALL have port viol_req, input, 6 bits: per-monitor violation requests, bit0 X_stack, bit1 AC, bit2 atomicity, bit3 dma_AC, bit4 dma_detect, bit5 dma_X_stack.
REQ-007 The block SHALL have port cause_clr, input, 1 bit: software request to clear the cause register.
REQ-008 The block SHALL have port reset, output, 1 bit: the registered CPU reset request.
REQ-009 The block SHALL have port cause, output, 6 bits: the sticky violation-cause register, with the same bit order as viol_req.
REQ-010 The block SHALL have port viol_cnt, output, 8 bits: a saturating count of violation episodes.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, HOLD and WAIT_PC.
REQ-013 In IDLE, if viol_req is nonzero at an edge, the next state SHALL be HOLD, reset SHALL be 1 from the next cycle, and hold_cnt SHALL load HOLD_CYCLES-1.
REQ-014 The latency from viol_req being sampled high to reset high SHALL be exactly 1 cycle, and reset SHALL be driven from a register with no combinational path from viol_req.
REQ-015 In HOLD, hold_cnt SHALL decrement each cycle; when hold_cnt equals 0 the next state SHALL be WAIT_PC with reset returning to 0.
REQ-016 An isolated violation SHALL therefore hold reset high for exactly HOLD_CYCLES cycles.
REQ-017 A nonzero viol_req during HOLD SHALL reload hold_cnt with HOLD_CYCLES-1, extending the pulse, and SHALL NOT increment viol_cnt.
REQ-018 In WAIT_PC, pc equal to RESET_HANDLER with viol_req zero SHALL move the FSM to IDLE on the next edge.
REQ-019 In WAIT_PC, a nonzero viol_req SHALL take priority over a pc match: the next state SHALL be HOLD, hold_cnt SHALL reload, and the event SHALL count as a new episode.
REQ-020 Every sampled nonzero viol_req, in any state, SHALL OR its bits into cause, so simultaneous violations all set their bits.
REQ-021 cause_clr SHALL zero cause only when the state is IDLE and viol_req is zero; otherwise it SHALL be ignored.
REQ-022 If cause_clr and a nonzero viol_req coincide in IDLE, cause SHALL equal that viol_req, with the new violation winning.
REQ-023 viol_cnt SHALL increment by 1 on each IDLE->HOLD or WAIT_PC->HOLD transition, SHALL saturate at 8'hFF, and SHALL NOT wrap.
REQ-024 viol_cnt SHALL be cleared only by reset_n.
REQ-025 busy SHALL be registered: 1 in HOLD and WAIT_PC, 0 in IDLE.

Reset
REQ-026 While reset_n is 0 at an edge, the next state SHALL be IDLE, with reset=0, cause=6'h00, viol_cnt=8'h00, busy=0 and hold_cnt=0.
REQ-027 reset_n asserted mid-HOLD or mid-WAIT_PC SHALL abort the sequence immediately, with reset deasserting on the next cycle.
REQ-028 viol_req and cause_clr SHALL be ignored while reset_n is 0.
REQ-029 After reset_n deasserts, the first edge SHALL sample viol_req normally.

Verification
REQ-030 With HOLD_CYCLES=8, a one-cycle pulse viol_req=6'h02 in IDLE -> reset high for exactly 8 cycles starting 1 cycle later, cause=6'h02, viol_cnt=1, busy high until pc=16'h0000 is seen.
REQ-031 viol_req=6'h21 in a single cycle -> cause=6'h21 and viol_cnt=1.
REQ-032 viol_req=6'h04 at HOLD cycle 5 -> reset high 8 further cycles (13 total), cause=6'h06, viol_cnt unchanged at 1.
REQ-033 In WAIT_PC, viol_req=6'h08 in the same cycle as pc=16'h0000 -> FSM returns to HOLD, viol_cnt=2, cause=6'h0A.
REQ-034 300 separated violations -> viol_cnt stops at 8'hFF; cause_clr pulsed in HOLD -> cause unchanged; cause_clr pulsed in IDLE -> cause=6'h00.
REQ-035 reset_n=0 at HOLD cycle 3 -> the next cycle shows reset=0, busy=0, cause=0 and viol_cnt=0.

Source files
------------

// File: rtl/vrased_reset_seq.sv
// vrased_reset_seq
//   Turns VRASED monitor violation requests into a registered CPU reset
//   pulse. It records which monitors fired in a sticky cause register and
//   counts violation episodes. After the pulse, the block waits for the CPU
//   to re-enter its reset handler before it returns to IDLE.
//
// Parameters
//   RESET_HANDLER  PC value that marks re-entry to the reset vector
//   HOLD_CYCLES    reset pulse length in cycles (legal range 1..255)
//
// Ports
//   clk        single clock; all state changes on its rising edge
//   reset_n    synchronous active-low block reset
//   pc         CPU program counter
//   viol_req   per-monitor violation requests:
//              [0] X_stack, [1] AC, [2] atomicity,
//              [3] dma_AC, [4] dma_detect, [5] dma_X_stack
//   cause_clr  software request to clear the cause register
//   reset      registered CPU reset request
//   cause      sticky violation cause, same bit order as viol_req
//   viol_cnt   saturating count of violation episodes
//   busy       high while the sequence is not IDLE
module vrased_reset_seq #(
  parameter logic [15:0] RESET_HANDLER = 16'h0000,
  parameter int unsigned HOLD_CYCLES   = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] pc,
  input  logic [5:0]  viol_req,
  input  logic        cause_clr,
  output logic        reset,
  output logic [5:0]  cause,
  output logic [7:0]  viol_cnt,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    WAIT_PC = 2'd2
  } state_e;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic [5:0]  cause_q, cause_d;
  logic [7:0]  viol_cnt_q, viol_cnt_d;
  logic        reset_q, busy_q;
  logic        viol_any;

  assign viol_any = |viol_req;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    viol_cnt_d = viol_cnt_q;
    cause_d    = cause_q | viol_req;

    // A clear in IDLE drops the old causes. Any violation sampled on the
    // same edge still lands in the register, so the new one wins.
    if (state_q == IDLE && cause_clr) begin
      cause_d = viol_req;
    end

    unique case (state_q)
      IDLE: begin
        if (viol_any) begin
          state_d    = HOLD;
          hold_cnt_d = HOLD_LOAD;
          if (viol_cnt_q != '1) viol_cnt_d = viol_cnt_q + 8'd1;
        end
      end
      HOLD: begin
        // A violation during the pulse extends it. It is part of the same
        // episode, so it is not counted again.
        if (viol_any) begin
          hold_cnt_d = HOLD_LOAD;
        end else if (hold_cnt_q == '0) begin
          state_d = WAIT_PC;
        end else begin
          hold_cnt_d = hold_cnt_q - 8'd1;
        end
      end
      WAIT_PC: begin
        // A new violation takes priority over the CPU reaching its handler.
        if (viol_any) begin
          state_d    = HOLD;
          hold_cnt_d = HOLD_LOAD;
          if (viol_cnt_q != '1) viol_cnt_d = viol_cnt_q + 8'd1;
        end else if (pc == RESET_HANDLER) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      cause_q    <= '0;
      viol_cnt_q <= '0;
      reset_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      cause_q    <= cause_d;
      viol_cnt_q <= viol_cnt_d;
      // reset and busy are decoded from the next state, so each one comes
      // straight from a flop and is aligned with state_q.
      reset_q    <= (state_d == HOLD);
      busy_q     <= (state_d != IDLE);
    end
  end

  assign reset    = reset_q;
  assign busy     = busy_q;
  assign cause    = cause_q;
  assign viol_cnt = viol_cnt_q;

endmodule

// File: tb/tb_vrased_reset_seq.sv
module tb_vrased_reset_seq;

  localparam int          HC = 8;
  localparam logic [15:0] RH = 16'h0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] pc;
  logic [5:0]  viol_req;
  logic        cause_clr;
  logic        reset;
  logic [5:0]  cause;
  logic [7:0]  viol_cnt;
  logic        busy;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  vrased_reset_seq #(
    .RESET_HANDLER(RH),
    .HOLD_CYCLES  (HC)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .pc       (pc),
    .viol_req (viol_req),
    .cause_clr(cause_clr),
    .reset    (reset),
    .cause    (cause),
    .viol_cnt (viol_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       bsy;
    logic [5:0] cau;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];

  // Reference model state. st: 0 = IDLE, 1 = HOLD, 2 = WAIT_PC.
  // rem is the number of reset-high cycles still to come.
  int         m_st    = 0;
  int         m_rem   = 0;
  logic [5:0] m_cause = '0;
  int         m_cnt   = 0;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [5:0] v, input logic c, input logic [15:0] p, input logic rn);
    if (!rn) begin
      m_st = 0; m_rem = 0; m_cause = '0; m_cnt = 0;
    end else if (v != 0) begin
      if (m_st != 1 && m_cnt < 255) m_cnt++;
      if (m_st == 0 && c) m_cause = v;
      else                m_cause = m_cause | v;
      m_st  = 1;
      m_rem = HC;
    end else begin
      if (m_st == 0 && c) m_cause = '0;
      if (m_st == 1) begin
        m_rem--;
        if (m_rem == 0) m_st = 2;
      end else if (m_st == 2 && p == RH) begin
        m_st = 0;
      end
    end
  endtask

  // Drive one cycle of stimulus, push the model's prediction, then pop it
  // and compare once the DUT has clocked.
  task automatic step(input logic [5:0] v, input logic c, input logic [15:0] p, input logic rn);
    exp_t e;
    viol_req = v; cause_clr = c; pc = p; reset_n = rn;
    model(v, c, p, rn);
    e.rst = (m_st == 1);
    e.bsy = (m_st != 0);
    e.cau = m_cause;
    e.cnt = 8'(m_cnt);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    check_eq("reset",    {15'd0, reset}, {15'd0, e.rst});
    check_eq("busy",     {15'd0, busy},  {15'd0, e.bsy});
    check_eq("cause",    {10'd0, cause}, {10'd0, e.cau});
    check_eq("viol_cnt", {8'd0, viol_cnt}, {8'd0, e.cnt});
  endtask

  task automatic idle(input int n, input logic [15:0] p);
    for (int i = 0; i < n; i++) step(6'h00, 1'b0, p, 1'b1);
  endtask

  task automatic do_reset();
    step(6'h00, 1'b0, 16'h1234, 1'b0);
    step(6'h00, 1'b0, 16'h1234, 1'b0);
  endtask

  int hi;

  initial begin
    viol_req = '0; cause_clr = 1'b0; pc = 16'h1234; reset_n = 1'b0;

    // Reset state. Inputs are ignored while reset_n is low.
    step(6'h3F, 1'b1, 16'h0000, 1'b0);
    do_reset();
    check_eq("rst_cause", {10'd0, cause}, 16'h0000);

    // Isolated violation: exactly HC cycles of reset, busy until pc hits the handler.
    hi = 0;
    step(6'h02, 1'b0, 16'h1234, 1'b1);
    if (reset) hi++;
    for (int i = 0; i < 12; i++) begin
      step(6'h00, 1'b0, 16'h1234, 1'b1);
      if (reset) hi++;
    end
    check_eq("pulse_len", 16'(hi), 16'd8);
    check_eq("busy_wait", {15'd0, busy}, 16'd1);
    check_eq("cause_02",  {10'd0, cause}, 16'h0002);
    step(6'h00, 1'b0, RH, 1'b1);
    check_eq("busy_done", {15'd0, busy}, 16'd0);

    // Clear coinciding with a new violation: the new violation wins.
    step(6'h21, 1'b1, 16'h1234, 1'b1);
    check_eq("cause_21", {10'd0, cause}, 16'h0021);
    check_eq("cnt_2",    {8'd0, viol_cnt}, 16'd2);

    // Simultaneous bits in a single cycle after a reset.
    do_reset();
    step(6'h21, 1'b0, 16'h1234, 1'b1);
    check_eq("cause_21b", {10'd0, cause}, 16'h0021);
    check_eq("cnt_1",     {8'd0, viol_cnt}, 16'd1);

    // A violation at HOLD cycle 5 extends the pulse to 13 cycles.
    do_reset();
    hi = 0;
    step(6'h02, 1'b0, 16'h1234, 1'b1);
    if (reset) hi++;
    idle(4, 16'h1234);
    hi += 4;
    step(6'h04, 1'b0, 16'h1234, 1'b1);
    if (reset) hi++;
    for (int i = 0; i < 12; i++) begin
      step(6'h00, 1'b0, 16'h1234, 1'b1);
      if (reset) hi++;
    end
    check_eq("ext_len",   16'(hi), 16'd13);
    check_eq("ext_cause", {10'd0, cause}, 16'h0006);
    check_eq("ext_cnt",   {8'd0, viol_cnt}, 16'd1);

    // In WAIT_PC a violation beats a pc match and counts as a new episode.
    do_reset();
    step(6'h02, 1'b0, 16'h1234, 1'b1);
    idle(HC, 16'h1234);
    check_eq("in_wait", {15'd0, reset}, 16'd0);
    step(6'h08, 1'b0, RH, 1'b1);
    check_eq("wp_reset", {15'd0, reset}, 16'd1);
    check_eq("wp_cnt",   {8'd0, viol_cnt}, 16'd2);
    check_eq("wp_cause", {10'd0, cause}, 16'h000A);

    // Saturation of viol_cnt, then cause_clr in HOLD and in IDLE.
    do_reset();
    for (int k = 0; k < 300; k++) begin
      step(6'h01, 1'b0, RH, 1'b1);
      idle(HC + 1, RH);
    end
    check_eq("cnt_sat", {8'd0, viol_cnt}, 16'h00FF);
    step(6'h10, 1'b0, RH, 1'b1);
    step(6'h00, 1'b1, RH, 1'b1);
    check_eq("clr_hold", {10'd0, cause}, 16'h0011);
    idle(HC + 1, RH);
    step(6'h00, 1'b1, RH, 1'b1);
    check_eq("clr_idle", {10'd0, cause}, 16'h0000);
    check_eq("cnt_kept", {8'd0, viol_cnt}, 16'h00FF);

    // reset_n in the middle of HOLD aborts the sequence at once.
    step(6'h02, 1'b0, 16'h1234, 1'b1);
    idle(2, 16'h1234);
    step(6'h04, 1'b1, 16'h1234, 1'b0);
    check_eq("abort_reset", {15'd0, reset}, 16'd0);
    check_eq("abort_busy",  {15'd0, busy},  16'd0);
    check_eq("abort_cause", {10'd0, cause}, 16'h0000);
    check_eq("abort_cnt",   {8'd0, viol_cnt}, 16'd0);
    // The first edge after reset_n rises samples viol_req normally.
    step(6'h20, 1'b0, 16'h1234, 1'b1);
    check_eq("post_rst", {15'd0, reset}, 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
